// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx parallel-in serial-out transmitter.
// Provides the FSM state enum, counter-width helper and default idle level.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_LEVEL_DEF = 1'b0;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_tx_bit_timer.sv
// Bit-period timer: counts clk cycles within one serial bit of piso_tx.
// Ports: clk, reset (sync, active-high), run, restart in; tick out (last cycle of period).
module bit_timer
    import piso_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = run & (cnt == LAST);

    // Cleared explicitly at terminal count so it never relies on overflow.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding register.
// Ports: clk, reset, in_data/in_valid/in_ready handshake; sdata, sframe,
// word_done (last cycle of a word) and busy outputs.
module piso_tx
    import piso_pkg::*;
#(
    parameter int   WIDTH        = 8,
    parameter int   CLKS_PER_BIT = 1,
    parameter int   LSB_FIRST    = 0,
    parameter logic IDLE_LEVEL   = IDLE_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             word_done,
    output logic             busy
);

    localparam int BW = cnt_w(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [BW-1:0]    bitcnt;
    logic [BW-1:0]    bitcnt_n;
    logic             sdata_n;
    logic             load;
    logic             tick;
    logic             last_bit;
    logic             accept;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (state == SHIFT),
        .restart(load && (state == IDLE)),
        .tick   (tick)
    );

    assign in_ready  = ~hold_full & ~reset;
    assign accept    = in_valid & in_ready;
    assign last_bit  = (bitcnt == LAST_BIT);
    assign word_done = (state == SHIFT) & tick & last_bit;
    assign busy      = (state == SHIFT) | hold_full;

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_full) begin
                    load     = 1'b1;
                    state_n  = SHIFT;
                    shreg_n  = hold;
                    bitcnt_n = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (last_bit) begin
                        bitcnt_n = '0;
                        // A held word follows with no idle gap.
                        if (hold_full) begin
                            load    = 1'b1;
                            shreg_n = hold;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                        if (LSB_FIRST != 0) begin
                            shreg_n = {1'b0, shreg[WIDTH-1:1]};
                        end else begin
                            shreg_n = {shreg[WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // sdata is registered, so it is computed from the next shifter value.
        sdata_n = IDLE_LEVEL;
        if (state_n == SHIFT) begin
            sdata_n = (LSB_FIRST != 0) ? shreg_n[0] : shreg_n[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bitcnt    <= '0;
            sdata     <= IDLE_LEVEL;
            sframe    <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            bitcnt <= bitcnt_n;
            sdata  <= sdata_n;
            sframe <= (state_n == SHIFT);
            if (accept) begin
                hold <= in_data;
            end
            // load needs hold_full and accept needs ~hold_full: never both.
            if (load) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed vector table, corner sequences
// and a queue-based bit-stream reference model with a loopback receiver.
module tb_piso_tx;

    logic       clk;
    logic       reset;
    logic [7:0] data_i [2];
    logic [1:0] valid_i;
    logic [1:0] ready_o;
    logic [1:0] sdata_o;
    logic [1:0] sframe_o;
    logic [1:0] done_o;
    logic [1:0] busy_o;

    int n_chk;
    int n_fail;

    // Instance 0: CPB=1, MSB first, idle 0. Instance 1: CPB=3, LSB first, idle 1.
    piso_tx #(
        .WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(0), .IDLE_LEVEL(1'b0)
    ) u_a (
        .clk(clk), .reset(reset), .in_data(data_i[0]), .in_valid(valid_i[0]),
        .in_ready(ready_o[0]), .sdata(sdata_o[0]), .sframe(sframe_o[0]),
        .word_done(done_o[0]), .busy(busy_o[0])
    );

    piso_tx #(
        .WIDTH(8), .CLKS_PER_BIT(3), .LSB_FIRST(1), .IDLE_LEVEL(1'b1)
    ) u_b (
        .clk(clk), .reset(reset), .in_data(data_i[1]), .in_valid(valid_i[1]),
        .in_ready(ready_o[1]), .sdata(sdata_o[1]), .sframe(sframe_o[1]),
        .word_done(done_o[1]), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic idle_lvl(input int k);
        return (k == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: every accepted word becomes its bit sequence in
    // transmit order, each bit repeated CPB times; the line must replay it.
    bit         qb [2][$];
    logic [7:0] qw [2][$];
    int         pos [2];
    int         wt [2];
    logic [7:0] rx;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                qb[k].delete();
                qw[k].delete();
                pos[k] = 0;
                wt[k] = 0;
            end else begin
                int   held;
                logic eb;
                logic [7:0] ew;
                held = qw[k].size() - (sframe_o[k] ? 1 : 0);
                chk("mon_busy", busy_o[k], (sframe_o[k] || qw[k].size() > 0));
                chk("mon_ready", ready_o[k], (held == 0));
                if (sframe_o[k]) begin
                    eb = (qb[k].size() > 0) ? qb[k].pop_front() : ~sdata_o[k];
                    chk("mon_bit", sdata_o[k], eb);
                    chk("mon_done", done_o[k], (pos[k] == 8 * cpb(k) - 1));
                    if (k == 0) rx = {rx[6:0], sdata_o[0]};
                    if (done_o[k]) begin
                        ew = (qw[k].size() > 0) ? qw[k].pop_front() : ~rx;
                        if (k == 0) chk("loopback", rx, ew);
                    end
                    pos[k] = (pos[k] == 8 * cpb(k) - 1) ? 0 : pos[k] + 1;
                    wt[k] = 0;
                end else begin
                    chk("mon_idle", sdata_o[k], idle_lvl(k));
                    chk("mon_done_idle", done_o[k], 1'b0);
                    if (qb[k].size() > 0) begin
                        wt[k]++;
                        chk("mon_latency", (wt[k] > 1), 1'b0);
                    end else begin
                        wt[k] = 0;
                    end
                end
                if (valid_i[k] && ready_o[k]) begin
                    qw[k].push_back(data_i[k]);
                    for (int j = 0; j < 8; j++) begin
                        for (int r = 0; r < cpb(k); r++) begin
                            qb[k].push_back(k == 1 ? data_i[k][j] : data_i[k][7-j]);
                        end
                    end
                end
            end
        end
    end

    // Directed single word on an idle transmitter; seq is in line order, first bit at [7].
    task automatic tx(input int k, input logic [7:0] w, input logic [7:0] seq);
        int t;
        int n;
        t = 0;
        n = 8 * cpb(k);
        data_i[k] = w;
        valid_i[k] = 1'b1;
        while (!ready_o[k] && t < 100) begin
            cyc();
            t++;
        end
        chk("tx_ready", ready_o[k], 1'b1);
        cyc();
        valid_i[k] = 1'b0;
        data_i[k] = 8'($urandom);
        chk("tx_latency", sframe_o[k], 1'b0);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("tx_sframe", sframe_o[k], 1'b1);
            chk("tx_sdata", sdata_o[k], seq[7 - i / cpb(k)]);
            chk("tx_done", done_o[k], (i == n - 1));
        end
        cyc();
        chk("tx_end_sframe", sframe_o[k], 1'b0);
        chk("tx_end_sdata", sdata_o[k], idle_lvl(k));
        chk("tx_end_busy", busy_o[k], 1'b0);
        chk("tx_end_ready", ready_o[k], 1'b1);
    endtask

    task automatic stream(input int k, input int n, input int maxgap);
        int t;
        int gap;
        for (int j = 0; j < n; j++) begin
            data_i[k] = 8'($urandom);
            valid_i[k] = 1'b1;
            t = 0;
            while (!ready_o[k] && t < 200) begin
                cyc();
                t++;
            end
            chk("stream_wait", (t < 200), 1'b1);
            cyc();
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (gap > 0) begin
                valid_i[k] = 1'b0;
                data_i[k] = 8'($urandom);
                repeat (gap) cyc();
            end
        end
        valid_i[k] = 1'b0;
        t = 0;
        while (busy_o[k] && t < 2000) begin
            cyc();
            t++;
        end
        cyc();
        chk("stream_drain", busy_o[k], 1'b0);
        chk("stream_bits_left", qb[k].size(), 0);
        chk("stream_words_left", qw[k].size(), 0);
    endtask

    typedef struct {
        int         k;
        logic [7:0] w;
        logic [7:0] seq;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [15:0] bits;
        int          acc;

        tbl[0] = '{0, 8'hA5, 8'b10100101};
        tbl[1] = '{0, 8'h96, 8'b10010110};
        tbl[2] = '{0, 8'h01, 8'b00000001};
        tbl[3] = '{1, 8'h01, 8'b10000000};
        tbl[4] = '{1, 8'h96, 8'b01101001};
        tbl[5] = '{1, 8'hF0, 8'b00001111};

        n_chk = 0;
        n_fail = 0;
        rx = '0;
        reset = 1'b1;
        valid_i = '0;
        data_i[0] = '0;
        data_i[1] = '0;
        repeat (3) cyc();
        chk("rst_ready_forced", ready_o, 2'b00);
        chk("rst_sframe", sframe_o, 2'b00);
        chk("rst_sdata", sdata_o, 2'b10);
        reset = 1'b0;
        #1;
        chk("rst_ready", ready_o, 2'b11);
        chk("rst_busy", busy_o, 2'b00);
        chk("rst_done", done_o, 2'b00);

        foreach (tbl[i]) tx(tbl[i].k, tbl[i].w, tbl[i].seq);

        // Back-to-back: 0x3C then 0xFF with in_valid held high.
        data_i[0] = 8'h3C;
        valid_i[0] = 1'b1;
        cyc();
        data_i[0] = 8'hFF;
        chk("b2b_full", ready_o[0], 1'b0);
        acc = -1;
        bits = '0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("b2b_sframe", sframe_o[0], 1'b1);
            bits[15 - i] = sdata_o[0];
            chk("b2b_done", done_o[0], (i == 7 || i == 15));
            if (acc >= 0 && valid_i[0]) valid_i[0] = 1'b0;
            else if (valid_i[0] && ready_o[0]) acc = i;
        end
        chk("b2b_accept_cycle", acc, 0);
        chk("b2b_bits", bits, 16'h3CFF);
        cyc();
        chk("b2b_end", sframe_o[0], 1'b0);

        // Backpressure: three words offered continuously.
        stream(0, 3, 0);

        // Reset mid-word with a second word held.
        data_i[0] = 8'hA5;
        valid_i[0] = 1'b1;
        cyc();
        data_i[0] = 8'h3C;
        cyc();
        cyc();
        valid_i[0] = 1'b0;
        cyc();
        chk("mid_sframe", sframe_o[0], 1'b1);
        chk("mid_held", ready_o[0], 1'b0);
        reset = 1'b1;
        cyc();
        chk("mr_sframe", sframe_o[0], 1'b0);
        chk("mr_sdata", sdata_o[0], 1'b0);
        chk("mr_ready_forced", ready_o[0], 1'b0);
        chk("mr_busy", busy_o[0], 1'b0);
        reset = 1'b0;
        #1;
        chk("mr_ready", ready_o[0], 1'b1);
        repeat (3) begin
            cyc();
            chk("mr_quiet", {sframe_o[0], done_o[0]}, 2'b00);
        end
        tx(0, 8'h81, 8'b10000001);

        // Random streams with loopback checking.
        stream(0, 30, 2);
        stream(1, 6, 1);
        stream(1, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
